// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the parametrised FIFO (fifo_param_flags).
//   FIFO_DEF_WIDTH / FIFO_DEF_DEPTH : default data width and entry count
//   FIFO_MODE_REGISTERED / FWFT     : read-mode selector values for FWFT
//   fifo_clog2()                    : pointer width for a given depth
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DEF_WIDTH       = 32;
    localparam int FIFO_DEF_DEPTH       = 16;

    // Read-mode selector: registered read or first-word-fall-through.
    localparam int FIFO_MODE_REGISTERED = 0;
    localparam int FIFO_MODE_FWFT       = 1;
    localparam int FIFO_DEF_MODE        = FIFO_MODE_REGISTERED;

    // Ceiling log2, used at elaboration time to size the pointers.
    function automatic int fifo_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// FDEPTH x FWIDTH storage for the FIFO: synchronous write, asynchronous read.
// The asynchronous read port lets the top level present the head word
// combinationally in first-word-fall-through mode and capture it into the
// output register in registered mode.
//   clk        : clock, rising edge
//   wr_en_i    : write enable
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address
//   rd_data_o  : read data (combinational from rd_addr_i)
// Contents are never cleared; only the pointers in the top level are reset.
// -----------------------------------------------------------------------------
module fifo_ram #(
    parameter int FWIDTH = 32,
    parameter int FDEPTH = 16,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [AWIDTH-1:0] wr_addr_i,
    input  logic [FWIDTH-1:0] wr_data_i,
    input  logic [AWIDTH-1:0] rd_addr_i,
    output logic [FWIDTH-1:0] rd_data_o
);

    logic [FWIDTH-1:0] mem_q [FDEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_param_flags.sv
// -----------------------------------------------------------------------------
// fifo_param_flags
// Parametrised single-clock FIFO with active-low strobes and flags,
// programmable almost-full / almost-empty thresholds, occupancy count and
// sticky overflow / underflow error flags.
//
// Ports:
//   Clk        : clock, rising edge
//   Rst        : synchronous reset, active-high (highest priority)
//   FClrN      : synchronous clear, active-low (below Rst, above read/write)
//   FInN       : write strobe, active-low
//   FOutN      : read strobe, active-low
//   Data_In    : write data
//   AFullThr   : almost-full threshold  (F_AFullN low when count >= AFullThr)
//   AEmptyThr  : almost-empty threshold (F_AEmptyN low when count <= AEmptyThr)
//   F_Data     : read data (registered read, or head word when FWFT=1)
//   F_Count    : occupancy 0..FDEPTH
//   F_FullN / F_EmptyN / F_FirstN / F_LastN / F_SLastN : count decodes, active-low
//   F_AFullN / F_AEmptyN : threshold flags, active-low
//   F_OvfErr   : sticky, write attempted while full without a same-cycle read
//   F_UdfErr   : sticky, read attempted while empty
// -----------------------------------------------------------------------------
module fifo_param_flags
    import fifo_pkg::*;
#(
    parameter int FWIDTH  = FIFO_DEF_WIDTH,
    parameter int FDEPTH  = FIFO_DEF_DEPTH,
    parameter int FCWIDTH = fifo_clog2(FDEPTH),
    parameter int FWFT    = FIFO_DEF_MODE
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               FClrN,
    input  logic               FInN,
    input  logic               FOutN,
    input  logic [FWIDTH-1:0]  Data_In,
    input  logic [FCWIDTH:0]   AFullThr,
    input  logic [FCWIDTH:0]   AEmptyThr,
    output logic [FWIDTH-1:0]  F_Data,
    output logic [FCWIDTH:0]   F_Count,
    output logic               F_FullN,
    output logic               F_EmptyN,
    output logic               F_FirstN,
    output logic               F_LastN,
    output logic               F_SLastN,
    output logic               F_AFullN,
    output logic               F_AEmptyN,
    output logic               F_OvfErr,
    output logic               F_UdfErr
);

    // Count-domain constants (FCWIDTH+1 bits so FDEPTH itself is representable).
    localparam logic [FCWIDTH:0] DEPTH_C  = FDEPTH[FCWIDTH:0];
    localparam logic [FCWIDTH:0] DEPTH_M1 = DEPTH_C - 1'b1;
    localparam logic [FCWIDTH:0] DEPTH_M2 = DEPTH_C - 2'd2;
    localparam logic [FCWIDTH:0] ONE_C    = 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [FCWIDTH-1:0] wptr_q,  wptr_d;
    logic [FCWIDTH-1:0] rptr_q,  rptr_d;
    logic [FCWIDTH:0]   count_q, count_d;
    logic [FWIDTH-1:0]  data_q,  data_d;
    logic               ovf_q,   ovf_d;
    logic               udf_q,   udf_d;

    logic [FWIDTH-1:0]  ram_rdata;
    logic               full;
    logic               empty;
    logic               wr_req;
    logic               rd_req;
    logic               wr_acc;
    logic               rd_acc;

    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    assign wr_req = ~FInN;
    assign rd_req = ~FOutN;

    // A read only needs data present. A write into a full FIFO is still
    // accepted when a read frees the slot in the same cycle; when empty the
    // read is rejected, so there is no write-through path.
    assign rd_acc = rd_req & ~empty;
    assign wr_acc = wr_req & (~full | rd_acc);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    fifo_ram #(
        .FWIDTH (FWIDTH),
        .FDEPTH (FDEPTH),
        .AWIDTH (FCWIDTH)
    ) u_ram (
        .clk       (Clk),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wptr_q),
        .wr_data_i (Data_In),
        .rd_addr_i (rptr_q),
        .rd_data_o (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;

        // Pointers wrap naturally at FDEPTH (power of two).
        if (wr_acc) begin
            wptr_d = wptr_q + 1'b1;
        end

        // The word leaving the FIFO is captured in both modes: in registered
        // mode it is the new output, in FWFT mode it is what F_Data keeps
        // showing once the FIFO runs empty.
        if (rd_acc) begin
            rptr_d = rptr_q + 1'b1;
            data_d = ram_rdata;
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        if (wr_req && full && !rd_acc) begin
            ovf_d = 1'b1;
        end
        if (rd_req && empty) begin
            udf_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers: Rst > clear > normal operation
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (!FClrN) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    generate
        if (FWFT != FIFO_MODE_REGISTERED) begin : g_fwft
            // Head word is visible as soon as it is stored; hold the last
            // consumed word while empty.
            assign F_Data = empty ? data_q : ram_rdata;
        end else begin : g_registered
            assign F_Data = data_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Flag decode, straight from the registered count
    // ------------------------------------------------------------------
    assign F_Count   = count_q;
    assign F_FullN   = ~full;
    assign F_EmptyN  = ~empty;
    assign F_FirstN  = ~(count_q == ONE_C);
    assign F_LastN   = ~(count_q == DEPTH_M1);
    assign F_SLastN  = ~(count_q == DEPTH_M2);
    // Thresholds are live inputs; out-of-range values simply never (or
    // always) compare true, which gives the intended saturating behaviour.
    assign F_AFullN  = ~(count_q >= AFullThr);
    assign F_AEmptyN = ~(count_q <= AEmptyThr);
    assign F_OvfErr  = ovf_q;
    assign F_UdfErr  = udf_q;

endmodule

// File: tb/tb_fifo_param_flags.sv
// -----------------------------------------------------------------------------
// tb_fifo_param_flags
// Directed bench for fifo_param_flags: a registered-read instance (dut0) and a
// first-word-fall-through instance (dut1), both 16 x 32.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_param_flags;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int CW = 4;

    logic          Clk;
    logic          Rst;

    // Registered-read instance
    logic          FClrN, FInN, FOutN;
    logic [W-1:0]  Data_In;
    logic [CW:0]   AFullThr, AEmptyThr;
    logic [W-1:0]  F_Data;
    logic [CW:0]   F_Count;
    logic          F_FullN, F_EmptyN, F_FirstN, F_LastN, F_SLastN;
    logic          F_AFullN, F_AEmptyN, F_OvfErr, F_UdfErr;

    // FWFT instance
    logic          f1_FClrN, f1_FInN, f1_FOutN;
    logic [W-1:0]  f1_Data_In;
    logic [W-1:0]  f1_F_Data;
    logic [CW:0]   f1_F_Count;
    logic          f1_F_FullN, f1_F_EmptyN, f1_F_FirstN, f1_F_LastN, f1_F_SLastN;
    logic          f1_F_AFullN, f1_F_AEmptyN, f1_F_OvfErr, f1_F_UdfErr;

    int n_checks;
    int n_errors;

    fifo_param_flags #(.FWIDTH(W), .FDEPTH(D), .FCWIDTH(CW), .FWFT(0)) dut0 (
        .Clk       (Clk),
        .Rst       (Rst),
        .FClrN     (FClrN),
        .FInN      (FInN),
        .FOutN     (FOutN),
        .Data_In   (Data_In),
        .AFullThr  (AFullThr),
        .AEmptyThr (AEmptyThr),
        .F_Data    (F_Data),
        .F_Count   (F_Count),
        .F_FullN   (F_FullN),
        .F_EmptyN  (F_EmptyN),
        .F_FirstN  (F_FirstN),
        .F_LastN   (F_LastN),
        .F_SLastN  (F_SLastN),
        .F_AFullN  (F_AFullN),
        .F_AEmptyN (F_AEmptyN),
        .F_OvfErr  (F_OvfErr),
        .F_UdfErr  (F_UdfErr)
    );

    fifo_param_flags #(.FWIDTH(W), .FDEPTH(D), .FCWIDTH(CW), .FWFT(1)) dut1 (
        .Clk       (Clk),
        .Rst       (Rst),
        .FClrN     (f1_FClrN),
        .FInN      (f1_FInN),
        .FOutN     (f1_FOutN),
        .Data_In   (f1_Data_In),
        .AFullThr  (AFullThr),
        .AEmptyThr (AEmptyThr),
        .F_Data    (f1_F_Data),
        .F_Count   (f1_F_Count),
        .F_FullN   (f1_F_FullN),
        .F_EmptyN  (f1_F_EmptyN),
        .F_FirstN  (f1_F_FirstN),
        .F_LastN   (f1_F_LastN),
        .F_SLastN  (f1_F_SLastN),
        .F_AFullN  (f1_F_AFullN),
        .F_AEmptyN (f1_F_AEmptyN),
        .F_OvfErr  (f1_F_OvfErr),
        .F_UdfErr  (f1_F_UdfErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks = n_checks + 1;
        if (observed !== expected) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [31:0] tail [5];
        logic [31:0] model_q [$];
        logic [31:0] exp_word;
        int          c;
        bit          wr_ok, rd_ok;

        n_checks   = 0;
        n_errors   = 0;
        Rst        = 1'b1;
        FClrN      = 1'b1;
        FInN       = 1'b1;
        FOutN      = 1'b1;
        Data_In    = '0;
        AFullThr   = 5'd14;
        AEmptyThr  = 5'd2;
        f1_FClrN   = 1'b1;
        f1_FInN    = 1'b1;
        f1_FOutN   = 1'b1;
        f1_Data_In = '0;

        // ---------------- reset ----------------
        tick();
        tick();
        Rst = 1'b0;
        tick();
        check_value("rst_count",   32'(F_Count), 32'd0);
        check_value("rst_emptyn",  32'(F_EmptyN), 32'd0);
        check_value("rst_fulln",   32'(F_FullN), 32'd1);
        check_value("rst_aemptyn", 32'(F_AEmptyN), 32'd0);
        check_value("rst_afulln",  32'(F_AFullN), 32'd1);
        check_value("rst_ovf",     32'(F_OvfErr), 32'd0);
        check_value("rst_udf",     32'(F_UdfErr), 32'd0);
        check_value("rst_data",    F_Data, 32'd0);
        $display("reset: count=%0d emptyn=%0b data=0x%0h", F_Count, F_EmptyN, F_Data);

        // ---------------- fill 0x00..0x0F ----------------
        for (int i = 0; i < 16; i++) begin
            FInN    = 1'b0;
            Data_In = 32'(i);
            tick();
            c = i + 1;
            check_value("fill_count",   32'(F_Count), 32'(c));
            check_value("fill_firstn",  32'(F_FirstN),  (c == 1)  ? 32'd0 : 32'd1);
            check_value("fill_aemptyn", 32'(F_AEmptyN), (c <= 2)  ? 32'd0 : 32'd1);
            check_value("fill_afulln",  32'(F_AFullN),  (c >= 14) ? 32'd0 : 32'd1);
            check_value("fill_slastn",  32'(F_SLastN),  (c == 14) ? 32'd0 : 32'd1);
            check_value("fill_lastn",   32'(F_LastN),   (c == 15) ? 32'd0 : 32'd1);
            check_value("fill_fulln",   32'(F_FullN),   (c == 16) ? 32'd0 : 32'd1);
            $display("write 0x%0h: count=%0d", Data_In, F_Count);
        end

        // 17th write while full is dropped
        Data_In = 32'hCDABEFDC;
        tick();
        FInN = 1'b1;
        check_value("ovf_count", 32'(F_Count), 32'd16);
        check_value("ovf_flag",  32'(F_OvfErr), 32'd1);
        $display("write 0x%0h on full: count=%0d ovf=%0b", Data_In, F_Count, F_OvfErr);

        // ---------------- drain 16 ----------------
        for (int i = 0; i < 16; i++) begin
            FOutN = 1'b0;
            tick();
            check_value("drain_data",  F_Data, 32'(i));
            check_value("drain_count", 32'(F_Count), 32'(15 - i));
            $display("read: data=0x%0h count=%0d", F_Data, F_Count);
        end
        // read on empty
        tick();
        FOutN = 1'b1;
        check_value("udf_flag",  32'(F_UdfErr), 32'd1);
        check_value("udf_data",  F_Data, 32'h0F);
        check_value("udf_count", 32'(F_Count), 32'd0);
        check_value("ovf_sticky", 32'(F_OvfErr), 32'd1);
        $display("read on empty: udf=%0b data=0x%0h", F_UdfErr, F_Data);

        // ---------------- clear ----------------
        FClrN = 1'b0;
        tick();
        FClrN = 1'b1;
        check_value("clr_ovf",  32'(F_OvfErr), 32'd0);
        check_value("clr_udf",  32'(F_UdfErr), 32'd0);
        check_value("clr_data", F_Data, 32'd0);
        $display("clear: ovf=%0b udf=%0b data=0x%0h", F_OvfErr, F_UdfErr, F_Data);

        // ---------------- simultaneous read+write ----------------
        for (int i = 0; i < 16; i++) begin
            FInN    = 1'b0;
            Data_In = 32'h100 + 32'(i);
            tick();
        end
        check_value("refill_count", 32'(F_Count), 32'd16);
        FOutN   = 1'b0;
        Data_In = 32'h200;
        tick();
        check_value("rw_full_count", 32'(F_Count), 32'd16);
        check_value("rw_full_data",  F_Data, 32'h100);
        check_value("rw_full_ovf",   32'(F_OvfErr), 32'd0);
        $display("rw on full: data=0x%0h count=%0d ovf=%0b", F_Data, F_Count, F_OvfErr);
        FInN = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            check_value("part_data", F_Data, 32'h100 + 32'(i));
        end
        check_value("part_count", 32'(F_Count), 32'd5);
        FInN    = 1'b0;
        Data_In = 32'h201;
        tick();
        FInN = 1'b1;
        check_value("rw_mid_count", 32'(F_Count), 32'd5);
        check_value("rw_mid_data",  F_Data, 32'h10C);
        $display("rw at 5: data=0x%0h count=%0d", F_Data, F_Count);
        tail = '{32'h10D, 32'h10E, 32'h10F, 32'h200, 32'h201};
        for (int i = 0; i < 5; i++) begin
            tick();
            check_value("tail_data",  F_Data, tail[i]);
            check_value("tail_count", 32'(F_Count), 32'(4 - i));
            $display("read: data=0x%0h count=%0d", F_Data, F_Count);
        end

        // read+write on empty: write only, underflow flagged
        FInN    = 1'b0;
        Data_In = 32'h300;
        tick();
        FInN  = 1'b1;
        check_value("rw_empty_count", 32'(F_Count), 32'd1);
        check_value("rw_empty_udf",   32'(F_UdfErr), 32'd1);
        check_value("rw_empty_data",  F_Data, 32'h201);
        $display("rw on empty: count=%0d udf=%0b data=0x%0h", F_Count, F_UdfErr, F_Data);
        tick();
        FOutN = 1'b1;
        check_value("rw_empty_rd", F_Data, 32'h300);

        // ---------------- wrap test with queue model ----------------
        for (int k = 0; k < 64; k++) begin
            FInN    = (k < 36) ? 1'b0 : 1'b1;
            FOutN   = ((k % 3) != 0) ? 1'b0 : 1'b1;
            Data_In = 32'h400 + 32'(k);
            rd_ok   = !FOutN && (model_q.size() > 0);
            wr_ok   = !FInN && ((model_q.size() < D) || rd_ok);
            exp_word = 32'h0;
            if (rd_ok) exp_word = model_q.pop_front();
            if (wr_ok) model_q.push_back(Data_In);
            tick();
            check_value("wrap_count", 32'(F_Count), 32'(model_q.size()));
            check_value("wrap_emptyn", 32'(F_EmptyN), (model_q.size() == 0) ? 32'd0 : 32'd1);
            if (rd_ok) begin
                check_value("wrap_data", F_Data, exp_word);
                $display("wrap cycle %0d: read 0x%0h count=%0d", k, F_Data, F_Count);
            end
        end
        FInN  = 1'b1;
        FOutN = 1'b1;

        // ---------------- live thresholds at count 0 ----------------
        AFullThr  = 5'd0;
        AEmptyThr = 5'd0;
        #1;
        check_value("thr_afull0",  32'(F_AFullN), 32'd0);
        check_value("thr_aempty0", 32'(F_AEmptyN), 32'd0);
        AFullThr  = 5'd17;
        #1;
        check_value("thr_afull17", 32'(F_AFullN), 32'd1);
        $display("thresholds: afulln=%0b aemptyn=%0b", F_AFullN, F_AEmptyN);
        AFullThr  = 5'd14;
        AEmptyThr = 5'd2;

        // ---------------- FWFT instance ----------------
        f1_FOutN = 1'b0;
        tick();
        f1_FOutN = 1'b1;
        check_value("fwft_udf", 32'(f1_F_UdfErr), 32'd1);
        f1_FInN    = 1'b0;
        f1_Data_In = 32'h98765432;
        tick();
        check_value("fwft_first_emptyn", 32'(f1_F_EmptyN), 32'd1);
        check_value("fwft_first_data",   f1_F_Data, 32'h98765432);
        $display("fwft write 0x98765432: emptyn=%0b data=0x%0h", f1_F_EmptyN, f1_F_Data);
        for (int i = 1; i <= 6; i++) begin
            f1_Data_In = 32'h10 + 32'(i);
            tick();
        end
        f1_FInN = 1'b1;
        check_value("fwft_count7",   32'(f1_F_Count), 32'd7);
        check_value("fwft_hold_head", f1_F_Data, 32'h98765432);
        f1_FClrN = 1'b0;
        tick();
        f1_FClrN = 1'b1;
        check_value("fwft_clr_count",  32'(f1_F_Count), 32'd0);
        check_value("fwft_clr_emptyn", 32'(f1_F_EmptyN), 32'd0);
        check_value("fwft_clr_udf",    32'(f1_F_UdfErr), 32'd0);
        check_value("fwft_clr_data",   f1_F_Data, 32'd0);
        $display("fwft clear: count=%0d emptyn=%0b udf=%0b", f1_F_Count, f1_F_EmptyN, f1_F_UdfErr);
        f1_FInN    = 1'b0;
        f1_Data_In = 32'hA5;
        tick();
        f1_FInN = 1'b1;
        check_value("fwft_a5", f1_F_Data, 32'hA5);
        f1_FOutN = 1'b0;
        tick();
        f1_FOutN = 1'b1;
        check_value("fwft_hold_empty", f1_F_Data, 32'hA5);
        check_value("fwft_empty_cnt",  32'(f1_F_Count), 32'd0);
        $display("fwft read to empty: data=0x%0h count=%0d", f1_F_Data, f1_F_Count);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
